// File: rtl/mdu_div.sv
// mdu_div: iterative restoring divider for MIPS DIV/DIVU (HI=remainder, LO=quotient).
// Optional macro DIV_EARLY_TERM_EN: finish at once when |dividend| < |divisor|.
module mdu_div #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic              signed_op,
   input  logic              cancel,
   input  logic [DATA_W-1:0] dividend,
   input  logic [DATA_W-1:0] divisor,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] quotient,
   output logic [DATA_W-1:0] remainder,
   output logic              div_by_zero,
   output logic              stall_req
);
   localparam int CNT_W = $clog2(DATA_W) + 1;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t            r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic [DATA_W-1:0] r_rem;
   logic [DATA_W-1:0] r_q;
   logic [DATA_W-1:0] r_divs;
   logic              r_neg_q;
   logic              r_neg_r;
   logic              r_dz;
   logic              w_accept;
   logic              w_zero;
   logic              w_early;
   logic [DATA_W-1:0] w_mag_a;
   logic [DATA_W-1:0] w_mag_b;
   logic [DATA_W:0]   w_sh;
   logic [DATA_W:0]   w_diff;
   assign w_accept  = r_state == IDLE && start && !cancel;
   assign w_zero    = divisor == '0;
   assign w_mag_a   = signed_op && dividend[DATA_W-1] ? -dividend : dividend;
   assign w_mag_b   = signed_op && divisor[DATA_W-1] ? -divisor : divisor;
`ifdef DIV_EARLY_TERM_EN
   assign w_early   = !w_zero && w_mag_a < w_mag_b;
`else
   assign w_early   = 1'b0;
`endif
   // Shifted partial remainder is one bit wider; bit DATA_W of the difference is the borrow.
   assign w_sh      = {r_rem, r_q[DATA_W-1]};
   assign w_diff    = w_sh - {1'b0, r_divs};
   assign busy      = r_state != IDLE;
   assign stall_req = w_accept || r_state == RUN;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_rem       <= '0;
         r_q         <= '0;
         r_divs      <= '0;
         r_neg_q     <= 1'b0;
         r_neg_r     <= 1'b0;
         r_dz        <= 1'b0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
      end else begin
         done <= 1'b0;
         case (r_state)
            IDLE: if (w_accept) begin
               div_by_zero <= 1'b0;
               r_dz        <= w_zero;
               r_cnt       <= CNT_W'(DATA_W);
               if (w_zero || w_early) begin
                  r_q     <= w_zero ? '1 : '0;
                  r_rem   <= dividend;
                  r_neg_q <= 1'b0;
                  r_neg_r <= 1'b0;
                  r_state <= DONE;
               end else begin
                  r_q     <= w_mag_a;
                  r_rem   <= '0;
                  r_divs  <= w_mag_b;
                  r_neg_q <= signed_op && (dividend[DATA_W-1] ^ divisor[DATA_W-1]);
                  r_neg_r <= signed_op && dividend[DATA_W-1];
                  r_state <= RUN;
               end
            end
            RUN: if (cancel) begin
               r_state <= IDLE;
            end else begin
               r_rem   <= w_diff[DATA_W] ? w_sh[DATA_W-1:0] : w_diff[DATA_W-1:0];
               r_q     <= {r_q[DATA_W-2:0], ~w_diff[DATA_W]};
               r_cnt   <= r_cnt - 1'b1;
               r_state <= r_cnt == CNT_W'(1) ? DONE : RUN;
            end
            DONE: begin
               r_state <= IDLE;
               if (!cancel) begin
                  done        <= 1'b1;
                  div_by_zero <= r_dz;
                  quotient    <= r_neg_q ? -r_q : r_q;
                  remainder   <= r_neg_r ? -r_rem : r_rem;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule
